// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads the combinational instruction memory,
// holds the fetched instruction in the IF/ID register and hands it to decode
// over a valid/ready handshake. Execute redirects take priority over fetch.
// Optional feature macro: FETCH_JUMP_PREDECODE_EN (J-type opcode 6'b000001
// steers the next PC to instr[15:0] at capture time).
//
// state | meaning
// BOOT  | first cycle after reset, no capture
// RUN   | normal fetch, capture when the IF/ID register can advance
// FLUSH | one-cycle bubble after a redirect, no capture
module instr_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_fetch_pc;
    logic            advance;
    logic            handshake;

    assign imem_pc   = pc;
    assign advance   = !id_valid || id_ready;
    assign handshake = id_valid && id_ready;

    // Address to fetch after a capture: sequential, or a predecoded jump target.
    always_comb begin
        next_fetch_pc = pc + PC_W'(1);
`ifdef FETCH_JUMP_PREDECODE_EN
        if (imem_instr[31:26] == 6'b000001) begin
            next_fetch_pc = PC_W'(imem_instr[15:0]);
        end
`endif
    end

    // Fetch FSM, PC, IF/ID register and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            fetch_count <= '0;
        end else begin
            // Counting is independent of redirects: a handshake completed in
            // the redirect cycle was still consumed by decode.
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                pc       <= redirect_pc;
                id_valid <= 1'b0;
                state    <= FLUSH;
            end else begin
                case (state)
                    BOOT: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (advance) begin
                            id_instr <= imem_instr;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            pc       <= next_fetch_pc;
                        end else if (handshake) begin
                            id_valid <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instruction memory returns {16'h0, pc}
// except at address 28, which holds a J to address 0 (32'h04000000).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_pc;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = (imem_pc == 16'd28) ? 32'h0400_0000 : {16'h0000, imem_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_after_jump;

    initial begin
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_after_jump = 16'd0;
`else
        exp_after_jump = 16'd29;
`endif
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'd0;

        // reset held three cycles
        repeat (3) step();
        check("rst_imem_pc", imem_pc, 32'd0);
        check("rst_id_valid", id_valid, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);

        rst      = 1'b0;
        id_ready = 1'b1;
        step();
        check("boot_id_valid", id_valid, 32'd0);
        check("boot_imem_pc", imem_pc, 32'd0);
        step();
        check("first_id_valid", id_valid, 32'd1);
        check("first_id_pc", id_pc, 32'd0);
        check("first_fetch_count", fetch_count, 32'd0);

        // streaming, one instruction per cycle
        for (int k = 1; k <= 5; k++) begin
            step();
            check("stream_id_pc", id_pc, 32'(k));
            check("stream_id_instr", id_instr, 32'(k));
            check("stream_fetch_count", fetch_count, 32'(k));
        end
        check("stream_imem_pc", imem_pc, 32'd6);

        // stall three cycles at id_pc=5
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_id_pc", id_pc, 32'd5);
            check("stall_imem_pc", imem_pc, 32'd6);
            check("stall_id_instr", id_instr, 32'd5);
            check("stall_fetch_count", fetch_count, 32'd5);
            check("stall_id_valid", id_valid, 32'd1);
        end
        id_ready = 1'b1;
        step();
        check("release_id_pc", id_pc, 32'd6);
        check("release_fetch_count", fetch_count, 32'd6);

        // redirect to 14 while stalled
        id_ready = 1'b0;
        step();
        check("stall2_id_pc", id_pc, 32'd6);
        check("stall2_imem_pc", imem_pc, 32'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 16'd14;
        step();
        redirect_valid = 1'b0;
        check("redir_id_valid", id_valid, 32'd0);
        check("redir_imem_pc", imem_pc, 32'd14);
        check("redir_fetch_count", fetch_count, 32'd6);
        step();
        check("flush_id_valid", id_valid, 32'd0);
        step();
        check("redir_id_pc", id_pc, 32'd14);
        check("redir_valid_back", id_valid, 32'd1);
        check("redir_fc_hold", fetch_count, 32'd6);

        // redirect to 28 coinciding with a handshake
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd28;
        step();
        redirect_valid = 1'b0;
        check("redir_hs_fetch_count", fetch_count, 32'd7);
        check("redir_hs_id_valid", id_valid, 32'd0);
        step();
        step();
        check("jump_id_pc", id_pc, 32'd28);
        check("jump_id_instr", id_instr, 32'h0400_0000);
        check("jump_imem_pc", imem_pc, 32'(exp_after_jump));
        step();
        check("after_jump_id_pc", id_pc, 32'(exp_after_jump));
        check("after_jump_fetch_count", fetch_count, 32'd8);

        // PC wrap at 16'hFFFF
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        check("wrap_redir_fc", fetch_count, 32'd9);
        step();
        step();
        check("wrap_id_pc", id_pc, 32'h0000_FFFF);
        check("wrap_id_instr", id_instr, 32'h0000_FFFF);
        check("wrap_imem_pc", imem_pc, 32'd0);
        step();
        check("wrap_next_id_pc", id_pc, 32'd0);
        check("wrap_fetch_count", fetch_count, 32'd10);

        // back-to-back redirects, latest wins
        redirect_valid = 1'b1;
        redirect_pc    = 16'd100;
        step();
        redirect_pc    = 16'd200;
        step();
        redirect_valid = 1'b0;
        check("b2b_imem_pc", imem_pc, 32'd200);
        check("b2b_id_valid", id_valid, 32'd0);
        check("b2b_fetch_count", fetch_count, 32'd11);

        // reset while in FLUSH
        rst = 1'b1;
        step();
        check("midflush_imem_pc", imem_pc, 32'd0);
        check("midflush_id_valid", id_valid, 32'd0);
        check("midflush_id_pc", id_pc, 32'd0);
        check("midflush_id_instr", id_instr, 32'd0);
        check("midflush_fetch_count", fetch_count, 32'd0);
        rst = 1'b0;
        step();
        check("reboot_id_valid", id_valid, 32'd0);
        step();
        check("reboot_first_valid", id_valid, 32'd1);
        check("reboot_first_id_pc", id_pc, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
